// File: rtl/clk_div_bank.sv
// Bank of independent clock dividers producing 50%-duty square waves.
// Divisor writes land in a shadow register and are applied only at a half-period boundary.
module clk_div_bank #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DEF_HALF = 50000,
  parameter int unsigned CH_W     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             phase_clr,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_half,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pending
);

  logic [CNT_W-1:0] act [N_CH];
  logic [CNT_W-1:0] shd [N_CH];
  logic [CNT_W-1:0] cnt [N_CH];
  logic [CNT_W-1:0] wr_val;
  logic [N_CH-1:0]  wr_hit;
  logic [N_CH-1:0]  wrap;

  // A zero half-period is meaningless; clamp it to the fastest legal rate.
  always_comb begin
    wr_val = (wr_half == '0) ? CNT_W'(1) : wr_half;
  end

  // Out-of-range channel numbers simply match no channel.
  always_comb begin
    wr_hit = '0;
    wrap   = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      wr_hit[i] = wr_en && (wr_ch == CH_W'(i));
      wrap[i]   = en && (cnt[i] == act[i] - CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        act[i] <= CNT_W'(DEF_HALF);
        shd[i] <= CNT_W'(DEF_HALF);
        cnt[i] <= '0;
      end
      clk_out <= '0;
      tick    <= '0;
      pending <= '0;
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        if (wr_hit[i]) shd[i] <= wr_val;
        if (phase_clr || wrap[i]) begin
          // Half-period boundary: safe point to adopt a new divisor.
          if (wr_hit[i])       act[i] <= wr_val;
          else if (pending[i]) act[i] <= shd[i];
          cnt[i]     <= '0;
          pending[i] <= 1'b0;
          if (phase_clr) begin
            clk_out[i] <= 1'b0;
            tick[i]    <= 1'b0;
          end else begin
            clk_out[i] <= ~clk_out[i];
            tick[i]    <= clk_out[i];
          end
        end else begin
          if (en) cnt[i] <= cnt[i] + CNT_W'(1);
          tick[i] <= 1'b0;
          if (wr_hit[i]) pending[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomised and directed bench for clk_div_bank against a countdown-based reference model.
module tb_clk_div_bank;
  localparam int unsigned N_CH     = 4;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned DEF_HALF = 3;
  localparam int unsigned CH_W     = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             phase_clr;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_half;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  pending;

  int n_chk = 0;
  int n_fail = 0;

  // Model: cycles remaining in the current half-period, counting down.
  int              m_act [N_CH];
  int              m_shd [N_CH];
  int              m_rem [N_CH];
  logic [N_CH-1:0] m_lvl;
  logic [N_CH-1:0] m_tk;
  logic [N_CH-1:0] m_pend;

  clk_div_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_HALF(DEF_HALF), .CH_W(CH_W)) dut (
    .clk(clk), .reset(reset), .en(en), .phase_clr(phase_clr), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_half(wr_half), .clk_out(clk_out), .tick(tick), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int val;
    bit w;
    val = (wr_half == '0) ? 1 : int'(wr_half);
    for (int c = 0; c < int'(N_CH); c++) begin
      w = wr_en && (int'(wr_ch) == c);
      if (!reset) begin
        m_act[c] = DEF_HALF; m_shd[c] = DEF_HALF; m_rem[c] = DEF_HALF;
        m_lvl[c] = 1'b0; m_tk[c] = 1'b0; m_pend[c] = 1'b0;
      end else if (phase_clr) begin
        if (w) begin m_shd[c] = val; m_act[c] = val; end
        else if (m_pend[c]) m_act[c] = m_shd[c];
        m_pend[c] = 1'b0; m_lvl[c] = 1'b0; m_tk[c] = 1'b0; m_rem[c] = m_act[c];
      end else begin
        m_tk[c] = 1'b0;
        if (en) m_rem[c] = m_rem[c] - 1;
        if (en && m_rem[c] == 0) begin
          if (w) begin m_shd[c] = val; m_act[c] = val; end
          else if (m_pend[c]) m_act[c] = m_shd[c];
          m_pend[c] = 1'b0;
          m_tk[c]   = m_lvl[c];
          m_lvl[c]  = ~m_lvl[c];
          m_rem[c]  = m_act[c];
        end else if (w) begin
          m_shd[c] = val; m_pend[c] = 1'b1;
        end
      end
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge, strobes dropped.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("clk_out", 32'(clk_out), 32'(m_lvl));
    chk("tick", 32'(tick), 32'(m_tk));
    chk("pending", 32'(pending), 32'(m_pend));
    wr_en = 1'b0;
    phase_clr = 1'b0;
    reset = 1'b1;
  endtask

  task automatic wr(input int ch, input int h);
    wr_ch = CH_W'(ch);
    wr_half = CNT_W'(h);
    wr_en = 1'b1;
    step();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic measure_high(input int ch, output int len);
    int guard;
    guard = 0;
    len = 0;
    while (clk_out[ch] === 1'b1 && guard < 100) begin step(); guard++; end
    while (clk_out[ch] !== 1'b1 && guard < 200) begin step(); guard++; end
    while (clk_out[ch] === 1'b1 && len < 100) begin step(); len++; end
  endtask

  initial begin
    int first_tick;
    int first_rise;
    int len;
    int guard;
    logic [N_CH-1:0] held;

    reset = 1'b0; en = 1'b0; phase_clr = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_half = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      m_act[c] = 0; m_shd[c] = 0; m_rem[c] = 0;
    end
    m_lvl = '0; m_tk = '0; m_pend = '0;
    step();
    reset = 1'b0;
    step();
    chk("rst_outputs", 32'({clk_out, tick, pending}), 32'(0));

    // Default rate: rise after 3 cycles, first tick after 6.
    en = 1'b1;
    first_tick = 0;
    first_rise = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      if (tick[0] === 1'b1 && first_tick == 0) first_tick = k;
      if (clk_out[0] === 1'b1 && first_rise == 0) first_rise = k;
    end
    chk("first_rise", 32'(first_rise), 32'(3));
    chk("first_tick", 32'(first_tick), 32'(6));

    // Divisor change during a high phase.
    guard = 0;
    while (!(clk_out[1] === 1'b1 && tick[1] === 1'b0) && guard < 20) begin step(); guard++; end
    wr(1, 5);
    chk("pend1_set", 32'(pending[1]), 32'(1));
    run(8);
    measure_high(1, len);
    chk("ch1_high5", 32'(len), 32'(5));
    measure_high(0, len);
    chk("ch0_high3", 32'(len), 32'(3));

    // Boundary writes: zero half and out-of-range channel.
    wr(0, 0);
    run(8);
    measure_high(0, len);
    chk("ch0_high1", 32'(len), 32'(1));
    wr(7, 2);
    run(12);

    // Enable hold.
    run(2);
    en = 1'b0;
    held = clk_out;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("en_hold", 32'(clk_out), 32'(held));
    end
    en = 1'b1;
    run(12);

    // phase_clr with channels out of phase and a coincident write.
    wr(0, 3); wr(1, 4); wr(2, 5);
    run(37);
    phase_clr = 1'b1;
    wr(3, 2);
    chk("pclr_out", 32'(clk_out), 32'(0));
    run(20);

    // Reset with a pending write.
    wr(2, 7);
    reset = 1'b0;
    step();
    chk("rst_mid", 32'({clk_out, tick, pending}), 32'(0));
    measure_high(2, len);
    chk("rst_def_half", 32'(len), 32'(DEF_HALF));

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) begin
        wr_en = 1'b1;
        wr_ch = CH_W'($urandom_range(0, 7));
        wr_half = CNT_W'($urandom_range(0, 7));
      end
      phase_clr = ($urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
